// File: rtl/sram_demux1to4.sv
// One-to-four SRAM-like request demultiplexer with address-window decode,
// registered read-data select and sticky capture of the first unmapped access.
module sram_demux1to4 #(
    parameter logic [31:0] BASE0         = 32'h0000_0000,
    parameter logic [31:0] MASK0         = 32'hFFF0_0000,
    parameter logic [31:0] BASE1         = 32'h1FAF_0000,
    parameter logic [31:0] MASK1         = 32'hFFFF_0000,
    parameter logic [31:0] BASE2         = 32'h1FC0_0000,
    parameter logic [31:0] MASK2         = 32'hFFF0_0000,
    parameter logic [31:0] BASE3         = 32'h2000_0000,
    parameter logic [31:0] MASK3         = 32'hF000_0000,
    parameter logic [31:0] DEFAULT_RDATA = 32'hDEAD_BEEF,
    parameter bit          REG_REQ       = 1'b0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         m_en,
    input  logic [3:0]   m_wen,
    input  logic [31:0]  m_addr,
    input  logic [31:0]  m_wdata,
    output logic [31:0]  m_rdata,
    output logic [3:0]   s_en,
    output logic [15:0]  s_wen,
    output logic [31:0]  s_addr,
    output logic [31:0]  s_wdata,
    input  logic [127:0] s_rdata,
    output logic         err,
    output logic [31:0]  err_addr,
    output logic         err_we,
    input  logic         err_clr
);

    // Effective (post-stage) request seen by decode and the slaves.
    logic        e_en;
    logic [3:0]  e_wen;
    logic [31:0] e_addr;
    logic [31:0] e_wdata;

    generate
        if (REG_REQ) begin : g_req_reg
            logic        q_en;
            logic [3:0]  q_wen;
            logic [31:0] q_addr;
            logic [31:0] q_wdata;

            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    q_en    <= 1'b0;
                    q_wen   <= 4'h0;
                    q_addr  <= 32'h0;
                    q_wdata <= 32'h0;
                end else begin
                    q_en    <= m_en;
                    q_wen   <= m_wen;
                    q_addr  <= m_addr;
                    q_wdata <= m_wdata;
                end
            end

            assign e_en    = q_en;
            assign e_wen   = q_wen;
            assign e_addr  = q_addr;
            assign e_wdata = q_wdata;
        end else begin : g_req_comb
            assign e_en    = m_en;
            assign e_wen   = m_wen;
            assign e_addr  = m_addr;
            assign e_wdata = m_wdata;
        end
    endgenerate

    logic [3:0] hit;
    logic [3:0] win;
    logic [1:0] sel;
    logic       miss;

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        hit[0] = ((e_addr & MASK0) == BASE0);
        hit[1] = ((e_addr & MASK1) == BASE1);
        hit[2] = ((e_addr & MASK2) == BASE2);
        hit[3] = ((e_addr & MASK3) == BASE3);
        win    = 4'b0000;
        sel    = 2'd0;
        if (hit[0]) begin
            win = 4'b0001;
            sel = 2'd0;
        end else if (hit[1]) begin
            win = 4'b0010;
            sel = 2'd1;
        end else if (hit[2]) begin
            win = 4'b0100;
            sel = 2'd2;
        end else if (hit[3]) begin
            win = 4'b1000;
            sel = 2'd3;
        end
        miss = (hit == 4'b0000);
    end

    assign s_en    = {4{e_en}} & win;
    assign s_wen   = {{4{win[3]}} & e_wen, {4{win[2]}} & e_wen,
                      {4{win[1]}} & e_wen, {4{win[0]}} & e_wen};
    assign s_addr  = e_addr;
    assign s_wdata = e_wdata;

    logic [1:0] sel_q;
    logic       miss_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel_q  <= 2'd0;
            miss_q <= 1'b0;
        end else if (e_en) begin
            sel_q  <= sel;
            miss_q <= miss;
        end
    end

    assign m_rdata = miss_q ? DEFAULT_RDATA : s_rdata[{sel_q, 5'b0} +: 32];

    // A new miss overrides a same-cycle clear so the latest error is never lost.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err      <= 1'b0;
            err_addr <= 32'h0;
            err_we   <= 1'b0;
        end else if (e_en && miss) begin
            err <= 1'b1;
            if (!err || err_clr) begin
                err_addr <= e_addr;
                err_we   <= (e_wen != 4'h0);
            end
        end else if (err_clr) begin
            err <= 1'b0;
        end
    end

endmodule
